// File: rtl/lfsr_range_rng.sv
// Fibonacci-LFSR random number generator with an inclusive [min, max] acceptance
// window, optional no-repeat rejection and a bounded retry count that ends in ERR.
module lfsr_range_rng #(
    parameter int           N    = 8,
    parameter logic [N-1:0] TAPS = N'(8'hB8),
    parameter logic [N-1:0] SEED = N'(1)
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_fSeed,
    input  logic [N-1:0] i_Seed,
    input  logic         i_fShuffle,
    input  logic         i_fStop,
    input  logic [N-1:0] i_Min,
    input  logic [N-1:0] i_Max,
    input  logic         i_fNoRepeat,
    output logic         o_fBusy,
    output logic         o_fRdy,
    output logic         o_fErr,
    output logic [N-1:0] o_Num
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHUFFLE  = 3'd1,
        WAIT_RDY = 3'd2,
        READY    = 3'd3,
        ERR      = 3'd4
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] lfsr, lfsr_nxt;
    logic [N-1:0] num, num_nxt;
    logic         last_valid, last_valid_nxt;
    logic [N-1:0] retry, retry_nxt;

    logic [N-1:0] cand;
    logic [N-1:0] seed_val;
    logic         in_range;
    logic         repeat_hit;
    logic         accept;
    logic         bad_range;

    // The candidate is always the stepped value; a zero seed would lock the LFSR.
    assign cand       = {lfsr[N-2:0], ^(lfsr & TAPS)};
    assign seed_val   = (i_Seed == '0) ? SEED : i_Seed;
    assign in_range   = (cand >= i_Min) && (cand <= i_Max);
    assign repeat_hit = i_fNoRepeat && last_valid && (cand == num);
    assign accept     = in_range && !repeat_hit;
    assign bad_range  = i_Min > i_Max;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            num        <= '0;
            last_valid <= 1'b0;
            retry      <= '0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            num        <= num_nxt;
            last_valid <= last_valid_nxt;
            retry      <= retry_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        lfsr_nxt       = lfsr;
        num_nxt        = num;
        last_valid_nxt = last_valid;
        retry_nxt      = retry;
        case (state)
            IDLE, READY, ERR: begin
                // Seed load wins over a simultaneous shuffle request.
                if (i_fSeed) begin
                    lfsr_nxt  = seed_val;
                    state_nxt = IDLE;
                end else if (i_fShuffle) begin
                    state_nxt = SHUFFLE;
                end
            end
            SHUFFLE: begin
                lfsr_nxt = cand;
                if (i_fStop) begin
                    if (bad_range) begin
                        state_nxt = ERR;
                    end else if (accept) begin
                        state_nxt      = READY;
                        num_nxt        = cand;
                        last_valid_nxt = 1'b1;
                        retry_nxt      = '0;
                    end else begin
                        state_nxt = WAIT_RDY;
                        retry_nxt = N'(1);
                    end
                end
            end
            WAIT_RDY: begin
                lfsr_nxt = cand;
                if (accept) begin
                    state_nxt      = READY;
                    num_nxt        = cand;
                    last_valid_nxt = 1'b1;
                    retry_nxt      = '0;
                end else if (retry == '1) begin
                    state_nxt = ERR;
                end else begin
                    retry_nxt = retry + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_fBusy = (state == SHUFFLE) || (state == WAIT_RDY);
    assign o_fRdy  = (state == READY);
    assign o_fErr  = (state == ERR);
    assign o_Num   = num;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Bench for lfsr_range_rng at N=4, TAPS=4'hC: directed scenarios plus random draws
// checked against a model that walks the known 15-entry LFSR sequence.
module tb_lfsr_range_rng;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         f_seed;
    logic [N-1:0] seed_in;
    logic         f_shuffle;
    logic         f_stop;
    logic [N-1:0] min_v;
    logic [N-1:0] max_v;
    logic         f_norep;
    logic         busy;
    logic         rdy;
    logic         err;
    logic [N-1:0] num;

    int checks = 0;
    int errors = 0;

    lfsr_range_rng #(.N(N), .TAPS(4'hC), .SEED(4'd1)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_fSeed    (f_seed),
        .i_Seed     (seed_in),
        .i_fShuffle (f_shuffle),
        .i_fStop    (f_stop),
        .i_Min      (min_v),
        .i_Max      (max_v),
        .i_fNoRepeat(f_norep),
        .o_fBusy    (busy),
        .o_fRdy     (rdy),
        .o_fErr     (err),
        .o_Num      (num)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // reference model: position in the maximal-length sequence
    logic [N-1:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                               4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    int           m_pos;
    logic [N-1:0] m_num;
    bit           m_last_valid;

    function automatic int idx_of(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 15; i++) if (seq[i] == v) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_pos        = 0;
        m_num        = '0;
        m_last_valid = 0;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_rdy"}, int'(rdy), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    // driver: shuffle then stop, wait for READY/ERR and compare with the model
    task automatic do_draw(input logic [N-1:0] lo, input logic [N-1:0] hi,
                           input logic nr, input bit seed_mid, input string tag);
        int           exp_evals;
        bit           exp_err;
        int           evals;
        bit           done;
        logic [N-1:0] c;
        exp_evals = 1;
        exp_err   = 1;
        if (lo > hi) begin
            m_pos = (m_pos + 1) % 15;
        end else begin
            exp_evals = 16;
            for (int i = 0; i < 16; i++) begin
                m_pos = (m_pos + 1) % 15;
                c = seq[m_pos];
                if (c >= lo && c <= hi && !(nr && m_last_valid && c == m_num)) begin
                    exp_evals    = i + 1;
                    exp_err      = 0;
                    m_num        = c;
                    m_last_valid = 1;
                    break;
                end
            end
        end
        @(negedge clk);
        f_shuffle = 1'b1;
        f_stop    = 1'b1;
        min_v     = lo;
        max_v     = hi;
        f_norep   = nr;
        @(negedge clk);
        f_shuffle = 1'b0;
        check({tag, "_busy_start"}, int'(busy), 1);
        evals = 0;
        done  = 0;
        while (!done && evals < 40) begin
            @(negedge clk);
            f_seed = 1'b0;
            evals++;
            if (rdy || err) begin
                done = 1;
            end else begin
                check({tag, "_busy_wait"}, int'(busy), 1);
                if (seed_mid && evals == 1) begin
                    f_seed  = 1'b1;
                    seed_in = N'($urandom_range(0, 15));
                end
            end
        end
        f_stop = 1'b0;
        f_seed = 1'b0;
        check({tag, "_evals"}, evals, exp_evals);
        check({tag, "_rdy"}, int'(rdy), exp_err ? 0 : 1);
        check({tag, "_err"}, int'(err), exp_err ? 1 : 0);
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_num"}, int'(num), int'(m_num));
    endtask

    task automatic do_seed(input logic [N-1:0] v, input logic with_shuffle, input string tag);
        @(negedge clk);
        f_seed    = 1'b1;
        seed_in   = v;
        f_shuffle = with_shuffle;
        @(negedge clk);
        f_seed    = 1'b0;
        f_shuffle = 1'b0;
        m_pos     = idx_of((v == '0) ? 4'd1 : v);
        check_idle_outputs(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        f_seed    = 1'b0;
        seed_in   = '0;
        f_shuffle = 1'b0;
        f_stop    = 1'b0;
        min_v     = '0;
        max_v     = '0;
        f_norep   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_num", int'(num), 0);
        rst_n = 1'b1;

        // 1: full range, first candidate accepted
        do_draw(4'd0, 4'd15, 1'b0, 0, "t1");
        check("t1_num_const", int'(num), 2);

        // 2: window [10,12], seven evaluations counting the stop edge
        apply_reset();
        do_draw(4'd10, 4'd12, 1'b0, 0, "t2");
        check("t2_num_const", int'(num), 10);

        // 3: only the last value is in range and repeats are rejected
        do_draw(4'd10, 4'd10, 1'b1, 0, "t3");
        check("t3_err_const", int'(err), 1);
        check("t3_num_const", int'(num), 10);

        // shuffle leaves ERR; 4: then an inverted window errors at once
        @(negedge clk);
        f_shuffle = 1'b1;
        @(negedge clk);
        f_shuffle = 1'b0;
        check("t3_leave_err_busy", int'(busy), 1);
        check("t3_leave_err_err", int'(err), 0);
        min_v  = 4'd9;
        max_v  = 4'd3;
        f_stop = 1'b1;
        @(negedge clk);
        f_stop = 1'b0;
        m_pos  = (m_pos + 1) % 15;
        check("t4_err", int'(err), 1);
        check("t4_busy", int'(busy), 0);
        check("t4_num", int'(num), 10);

        // 5: seed zero with shuffle in READY, then seed ignored mid-draw
        do_draw(4'd0, 4'd15, 1'b0, 0, "t5a");
        do_seed(4'd0, 1'b1, "t5_seed");
        do_draw(4'd0, 4'd15, 1'b0, 0, "t5b");
        check("t5b_num_const", int'(num), 2);
        do_draw(4'd10, 4'd12, 1'b0, 1, "t5c");
        check("t5c_num_const", int'(num), 10);

        // 6: asynchronous reset in the middle of WAIT_RDY
        @(negedge clk);
        f_shuffle = 1'b1;
        f_stop    = 1'b1;
        min_v     = 4'd10;
        max_v     = 4'd10;
        f_norep   = 1'b1;
        @(negedge clk);
        f_shuffle = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        check("t6_num", int'(num), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        f_stop = 1'b0;
        model_reset();
        do_draw(4'd0, 4'd15, 1'b0, 0, "t6_after");
        check("t6_after_num_const", int'(num), 2);

        // random draws and seed loads
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_seed(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rnd_seed");
            end else begin
                do_draw(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
